// File: rtl/fpga_cfg_loader.sv
// Streaming bitstream loader for the fpga fabric.
// Packs WORD_WIDTH-bit stream words into CFG_WIDTH-bit frames, strobes each
// frame into the fabric with a one-hot configs_en pulse, waits a settle
// interval, then raises ff_en followed by rdy.
// Optional build macro CFG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// word; without it the CHECK state and accumulator do not exist and err is 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, outputs quiet
// FILL   | accepting words of the current frame
// WRITE  | one-cycle one-hot strobe of the assembled frame
// CHECK  | accepting the checksum word (checksum build only)
// SETTLE | counting idle cycles after the last frame
// ARM    | ff_en high, one cycle before rdy
// DONE   | configuration complete, ff_en and rdy held high
module fpga_cfg_loader #(
  parameter int CFG_WIDTH     = 224,
  parameter int NUM_FRAMES    = 245,
  parameter int WORD_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [CFG_WIDTH-1:0]  configs_in,
  output logic [NUM_FRAMES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);

  localparam int WPF = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WIW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int FIW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WIW-1:0]        LAST_WORD   = WIW'(WPF - 1);
  localparam logic [FIW-1:0]        LAST_FRAME  = FIW'(NUM_FRAMES - 1);
  localparam logic [SCW-1:0]        SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_FRAMES-1:0] EN_ONE      = NUM_FRAMES'(1);
  localparam logic [CFG_WIDTH-1:0]  WORD_MASK   = CFG_WIDTH'({WORD_WIDTH{1'b1}});

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
`ifdef CFG_LOADER_CHECKSUM_EN
    CHECK,
`endif
    SETTLE,
    ARM,
    DONE
  } state_t;

  state_t               state;
  logic [WIW-1:0]       word_idx;
  logic [FIW-1:0]       frame_idx;
  logic [SCW-1:0]       settle_cnt;
  logic                 accept;
  logic [CFG_WIDTH-1:0] frame_next;

  assign accept = s_valid & s_ready;

  // Merge the incoming word into its slot; bits shifted past CFG_WIDTH fall off.
  always_comb begin
    frame_next = (configs_in & ~(WORD_MASK << (word_idx * WORD_WIDTH)))
               | (CFG_WIDTH'(s_data) << (word_idx * WORD_WIDTH));
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] xor_acc;
  logic                  err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Sequencer: all outputs registered, strobe self-clears after one cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      frame_idx  <= '0;
      settle_cnt <= '0;
      s_ready    <= 1'b0;
      configs_in <= '0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      busy       <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
      xor_acc    <= '0;
`endif
    end else begin
      configs_en <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FILL;
            word_idx  <= '0;
            frame_idx <= '0;
            ff_en     <= 1'b0;
            rdy       <= 1'b0;
            busy      <= 1'b1;
            s_ready   <= 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
            xor_acc   <= '0;
`endif
          end
        end
        FILL: begin
          if (accept) begin
            configs_in <= frame_next;
`ifdef CFG_LOADER_CHECKSUM_EN
            xor_acc    <= xor_acc ^ s_data;
`endif
            if (word_idx == LAST_WORD) begin
              state      <= WRITE;
              s_ready    <= 1'b0;
              configs_en <= EN_ONE << frame_idx;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          word_idx <= '0;
          if (frame_idx == LAST_FRAME) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            state   <= CHECK;
            s_ready <= 1'b1;
`else
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
`endif
          end else begin
            frame_idx <= frame_idx + 1'b1;
            state     <= FILL;
            s_ready   <= 1'b1;
          end
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (s_data == xor_acc) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              err_q <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
`endif
        SETTLE: begin
          if (settle_cnt == '0) begin
            ff_en <= 1'b1;
            state <= ARM;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ARM: begin
          rdy   <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Randomized self-checking bench for fpga_cfg_loader with a small fabric
// (40-bit frames, 4 frames, 16-bit words, 3 settle cycles).
// Expected frames and event cycles are computed from word lists and gap
// counts with plain arithmetic; the DUT's s_ready only paces the driver.
module tb_fpga_cfg_loader;
  localparam int CW  = 40;
  localparam int NF  = 4;
  localparam int WW  = 16;
  localparam int SC  = 3;
  localparam int WPF = 3;
  localparam int NW  = NF * WPF;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam int CKM = 1;
`else
  localparam int CKM = 0;
`endif

  logic          clock = 1'b0;
  logic          rst, start, s_valid, s_ready, ff_en, rdy, busy, err;
  logic [WW-1:0] s_data;
  logic [CW-1:0] configs_in;
  logic [NF-1:0] configs_en;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] w[NW+1];
  int            gaps[NW+1];

  always #5 clock = ~clock;

  fpga_cfg_loader #(
    .CFG_WIDTH(CW), .NUM_FRAMES(NF), .WORD_WIDTH(WW), .SETTLE_CYCLES(SC)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .configs_in(configs_in),
    .configs_en(configs_en), .ff_en(ff_en), .rdy(rdy), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_configs_in"}, configs_in, 0);
    chk({tag, "_configs_en"}, configs_en, 0);
    chk({tag, "_ff_en"}, ff_en, 0);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  // ck_mode: 0 no checksum word, 1 correct checksum, 2 corrupted checksum.
  // abort_at >= 0 stops driving once that many words were accepted.
  task automatic do_load(input int ngaps, input bit noise, input int ck_mode,
                         input int abort_at, input bit fixed_words);
    int            exp_strobe[NF];
    logic [CW-1:0] exp_frame[NF];
    logic [3*WW-1:0] cat;
    logic [WW-1:0] x;
    int acc, k, gap_left, nf, ff_cyc, rdy_cyc, err_cyc, c, t_edge, total, exp_ff;
    bit drove, done;

    for (int i = 0; i < NW; i++) w[i] = WW'($urandom);
    if (fixed_words) begin
      w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h0033;
    end
    x = '0;
    for (int i = 0; i < NW; i++) x = x ^ w[i];
    w[NW] = (ck_mode == 2) ? (x ^ (WW'(1) << $urandom_range(0, WW - 1))) : x;

    for (int i = 0; i <= NW; i++) gaps[i] = 0;
    for (int g = 0; g < ngaps; g++) gaps[$urandom_range(0, NW - 1)]++;

    acc = 0;
    for (int f = 0; f < NF; f++) begin
      acc += gaps[3*f] + gaps[3*f+1] + gaps[3*f+2];
      exp_strobe[f] = (f + 1) * (WPF + 1) + acc;
      cat = {w[3*f+2], w[3*f+1], w[3*f]};
      exp_frame[f] = cat[CW-1:0];
    end
    exp_ff = exp_strobe[NF-1] + ((ck_mode != 0) ? 1 : 0) + SC + 1;
    total  = NW + ((ck_mode != 0) ? 1 : 0);

    @(negedge clock);
    start = 1'b1; s_valid = 1'b0;
    @(posedge clock);
    t_edge = 0;
    k = 0; gap_left = gaps[0]; nf = 0;
    ff_cyc = -1; rdy_cyc = -1; err_cyc = -1; done = 1'b0;

    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clock);
      c = t_edge + 1;
      start = 1'b0;
      if (c == 1) begin
        chk("start_ff_en", ff_en, 0);
        chk("start_rdy", rdy, 0);
        chk("start_busy", busy, 1);
      end
      if (configs_en != 0) begin
        if (nf < NF) begin
          chk("strobe_onehot", configs_en, 64'(1) << nf);
          chk("strobe_cycle", c, exp_strobe[nf]);
          chk("frame_data", configs_in, exp_frame[nf]);
          if (fixed_words && nf == 0) chk("basic_frame0", configs_in, 40'h33_2222_1111);
          nf++;
        end else begin
          chk("extra_strobe", configs_en, 0);
        end
      end
      if (ff_en && ff_cyc < 0) ff_cyc = c;
      if (rdy && rdy_cyc < 0) begin rdy_cyc = c; done = 1'b1; end
      if (err && err_cyc < 0) begin err_cyc = c; done = 1'b1; end
      if (abort_at >= 0 && k >= abort_at) done = 1'b1;

      drove = 1'b0;
      if (!done && k < total) begin
        if (s_ready && gap_left > 0) begin
          s_valid = 1'b0;
          gap_left--;
        end else begin
          s_valid = 1'b1;
          s_data  = w[k];
          drove   = s_ready;
        end
      end else begin
        s_valid = 1'b0;
      end
      if (!done && noise && (c == 6 || c == exp_strobe[NF-1] + 2)) start = 1'b1;
      if (!done) begin
        @(posedge clock);
        t_edge++;
        if (drove) begin
          k++;
          if (k <= NW) gap_left = gaps[k];
        end
      end
    end
    start = 1'b0; s_valid = 1'b0;

    if (abort_at < 0) begin
      if (!done) chk("timeout", 0, 1);
      chk("frames_seen", nf, NF);
      if (ck_mode == 2) begin
        chk("err_cycle", err_cyc, exp_strobe[NF-1] + 2);
        chk("fail_ff_en", ff_en, 0);
        chk("fail_rdy", rdy, 0);
        chk("fail_busy", busy, 0);
        chk("fail_s_ready", s_ready, 0);
        repeat (3) @(negedge clock);
        chk("fail_err_sticky", err, 1);
        chk("fail_ff_en_hold", ff_en, 0);
        chk("fail_idle_s_ready", s_ready, 0);
      end else begin
        chk("ff_en_cycle", ff_cyc, exp_ff);
        chk("rdy_cycle", rdy_cyc, exp_ff + 1);
        chk("done_busy", busy, 0);
        chk("done_err", err, 0);
        chk("done_ff_en", ff_en, 1);
        chk("done_s_ready", s_ready, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    rst = 1'b0;

    // basic back-to-back load with the known first frame
    do_load(0, 1'b0, CKM, -1, 1'b1);
    // back-pressure gaps
    do_load(5, 1'b0, CKM, -1, 1'b0);
    // reset in the middle of a load, then a clean load
    do_load(0, 1'b0, CKM, 7, 1'b0);
    rst = 1'b1;
    @(posedge clock);
    #1;
    chk_all_zero("midrst");
    @(negedge clock);
    rst = 1'b0;
    do_load(0, 1'b0, CKM, -1, 1'b0);
    // reload from DONE with ignored start pulses
    do_load(3, 1'b1, CKM, -1, 1'b0);
    for (int r = 0; r < 3; r++) do_load($urandom_range(0, 8), 1'b1, CKM, -1, 1'b0);
`ifdef CFG_LOADER_CHECKSUM_EN
    do_load(2, 1'b0, 2, -1, 1'b0);
    do_load(0, 1'b0, 1, -1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Synthesizable bitstream loader that sits directly upstream of the `fpga` fabric.
- Accepts configuration words over a valid/ready stream and assembles them into CFG_WIDTH-bit frames.
- Writes each frame into the fabric by driving `configs_in` and a one-hot `configs_en` strobe.
- After all frames are written and a settle interval has elapsed, raises `ff_en` and then `rdy`, replacing the behavioural file-reading loader used in simulation wrappers.

Parameters:
- CFG_WIDTH, 224: fabric config frame width, in bits.
- NUM_FRAMES, 245: number of frames, equal to the width of `configs_en`.
- WORD_WIDTH, 32: width of the input stream word.
- SETTLE_CYCLES, 10: idle cycles after the last frame write, before `ff_en` rises.
- Derived: WPF = ceil(CFG_WIDTH/WORD_WIDTH), the number of words per frame.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a (re)load.
- s_data  in  WORD_WIDTH  config word.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  loader accepts a word this cycle.
- configs_in  out  CFG_WIDTH  frame data to the fabric, registered.
- configs_en  out  NUM_FRAMES  one-hot frame write strobe, registered.
- ff_en  out  1  fabric flip-flop enable.
- rdy  out  1  configuration complete.
- busy  out  1  load in progress.
- err  out  1  checksum failure, sticky until `start` or `rst`.

Behaviour:
- Clock and reset: one clock, named `clock`; reset `rst` is synchronous and active-high.
- Reset: the FSM goes to IDLE and every output is 0, including `configs_in`, `configs_en`, `ff_en`, `rdy`, `busy`, `err` and `s_ready`. This holds even when `rst` is asserted mid-load: partial frame data is discarded and no strobe is issued.
- Word transfer: a word is accepted only when `s_valid` and `s_ready` are both high. Stalls (`s_valid` low) may last any length.
- Frame packing: word j of a frame lands in `configs_in[j*WORD_WIDTH +: WORD_WIDTH]`. Bits of the last word above CFG_WIDTH are dropped. `configs_in` updates as words arrive and holds its value during the strobe and afterwards.
- States:
  - IDLE: `s_ready` = 0. On `start` → FILL; clear the frame and word counters, `err`, `ff_en` and `rdy`; set `busy` = 1.
  - FILL: `s_ready` = 1. Store each accepted word. After word WPF-1 is accepted → WRITE.
  - WRITE: exactly one cycle with `s_ready` = 0 and `configs_en` = 1 << frame_idx. Then increment frame_idx. If frame_idx was NUM_FRAMES-1 → SETTLE (or CHECK when the optional feature is enabled); otherwise → FILL with word_idx = 0.
  - SETTLE: `configs_en` = 0 for SETTLE_CYCLES cycles. Then `ff_en` = 1 → ARM.
  - ARM: one cycle. Then `rdy` = 1 and `busy` = 0 → DONE.
  - DONE: hold `ff_en` = 1 and `rdy` = 1. On `start`: `ff_en`, `rdy` ← 0 in the same update and → FILL, so the fabric is frozen during reconfiguration.
- `start` while `busy` is ignored.
- `configs_en` is never multi-hot and is 0 outside WRITE.
- Throughput with `s_valid` held high: WPF+1 cycles per frame.
  - `start` sampled at cycle 0; first strobe at cycle WPF+1.
  - Last strobe at cycle NUM_FRAMES*(WPF+1).
  - `ff_en` rises SETTLE_CYCLES+1 cycles after the last strobe; `rdy` rises one cycle after `ff_en`.
- Words presented while `s_ready` = 0 are not consumed.

Optional Feature:
- Macro: CFG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE → CHECK state, `s_ready` = 1; accept one extra word.
  - Compare that word against the running XOR of every data word accepted since `start`.
  - Match → SETTLE.
  - Mismatch → `err` = 1, `busy` = 0, → IDLE; `ff_en` and `rdy` stay 0.
- Undefined: no CHECK state, no XOR accumulator, and `err` is tied to 0.

Test Plan:
All cases use CFG_WIDTH=40, NUM_FRAMES=4, WORD_WIDTH=16, SETTLE_CYCLES=3 (WPF=3).
- Basic load: `start`, then 12 back-to-back words. Frame 0 = 1111, 2222, 0033 → `configs_in` = 40'h33_2222_1111 with `configs_en` = 4'b0001 at cycle 4; strobes 0010, 0100, 1000 at cycles 8, 12, 16; `ff_en` = 1 at cycle 20, `rdy` = 1 at cycle 21, `busy` = 0.
- Back-pressure: insert 5 random `s_valid` = 0 gaps → same frames and strobe order; each strobe delayed by its accumulated gaps; no word lost or duplicated.
- Reset mid-load: assert `rst` after 7 words → next cycle all outputs 0 and `s_ready` = 0; `start` plus 12 words completes normally.
- Reload: `start` in DONE → `ff_en` and `rdy` drop the next cycle; a second 12-word load re-raises them; `start` pulses during that load are ignored.
- Checksum pass (macro defined): 12 words plus the correct XOR word → `rdy` = 1, `err` = 0.
- Checksum fail (macro defined): 12 words plus the XOR word with one bit flipped → `err` = 1, `ff_en` = `rdy` = 0, state IDLE.
